// File: rtl/sigmoid_neuron_mac_if.sv
// Beat/result handshake bundle between a neuron MAC and its neighbours.
// The master drives beats and accepts results; the slave is the MAC itself.
interface sigmoid_neuron_mac_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] bias;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] z_value;
  logic              sat;

  modport master (output in_valid, x, w, bias, out_ready,
                  input  in_ready, out_valid, z_value, sat);
  modport slave  (input  in_valid, x, w, bias, out_ready,
                  output in_ready, out_valid, z_value, sat);
endinterface

// File: rtl/sigmoid_neuron_mac.sv
// Time-shared multiply-accumulate front end of one sigmoid neuron, Q4.4 in and out.
// Optional SIGMOID_NEURON_MAC_ROUND_EN: round half up before saturation instead of truncating.
module sigmoid_neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter int ACC_W    = 20
) (
  input  logic clk,
  input  logic rst_n,
  sigmoid_neuron_mac_if.slave bus
);
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((2 ** (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] R_MIN = -ACC_W'(2 ** (DATA_W-1));

  typedef enum logic [1:0] {S_ACC, S_FIN, S_OUT} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, r;
  logic                      beat, last;

  assign beat     = bus.in_valid && (state == S_ACC);
  assign last     = (cnt == CNT_W'(N_INPUTS - 1));
  assign prod     = $signed(bus.x) * $signed(bus.w);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias} <<< FRAC_W;

`ifdef SIGMOID_NEURON_MAC_ROUND_EN
  assign r = (acc + ACC_W'(2 ** (FRAC_W-1))) >>> FRAC_W;
`else
  assign r = acc >>> FRAC_W;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (beat && last) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_ACC);
    bus.out_valid = (state == S_OUT);
  end

  // Bias is folded into the first beat's sum, so it needs no register of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      bus.z_value <= '0;
      bus.sat     <= 1'b0;
    end else begin
      case (state)
        S_ACC: if (beat) begin
          acc <= (cnt == '0) ? bias_ext + prod_ext : acc + prod_ext;
          cnt <= last ? '0 : cnt + CNT_W'(1);
        end
        S_FIN: begin
          if (r > R_MAX) begin
            bus.z_value <= {1'b0, {(DATA_W-1){1'b1}}};
            bus.sat     <= 1'b1;
          end else if (r < R_MIN) begin
            bus.z_value <= {1'b1, {(DATA_W-1){1'b0}}};
            bus.sat     <= 1'b1;
          end else begin
            bus.z_value <= r[DATA_W-1:0];
            bus.sat     <= 1'b0;
          end
        end
        S_OUT: if (bus.out_ready) acc <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmoid_neuron_mac.sv
// Directed-vector bench for sigmoid_neuron_mac plus a randomized streaming phase.
module tb_sigmoid_neuron_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sigmoid_neuron_mac_if #(.DATA_W(8)) ifc ();
  sigmoid_neuron_mac #(.N_INPUTS(4), .DATA_W(8), .FRAC_W(4), .ACC_W(20))
    dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  typedef struct {
    string           name;
    logic [3:0][7:0] x;
    logic [3:0][7:0] w;
    logic [7:0]      bias;
    logic [7:0]      z;
    logic            sat;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];
  logic       exp_sat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic send_beat(input logic [7:0] xv, input logic [7:0] wv, input logic [7:0] bv);
    int t = 0;
    ifc.in_valid = 1'b1; ifc.x = xv; ifc.w = wv; ifc.bias = bv;
    while (!ifc.in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("beat_timeout", 32'd1, 32'd0);
    @(posedge clk); @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [7:0] ez, input logic es, input int hold);
    int t = 0;
    while (!ifc.out_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check({name, "_out_timeout"}, 32'd1, 32'd0);
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_z"}, 32'(ifc.z_value), 32'(ez));
      check({name, "_hold_inrdy"}, 32'(ifc.in_ready), 32'd0);
      @(negedge clk);
    end
    check({name, "_z"}, 32'(ifc.z_value), 32'(ez));
    check({name, "_sat"}, 32'(ifc.sat), 32'(es));
    ifc.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ifc.out_ready = 1'b0;
    check({name, "_done_ovld"}, 32'(ifc.out_valid), 32'd0);
    check({name, "_done_inrdy"}, 32'(ifc.in_ready), 32'd1);
  endtask

  function automatic logic [8:0] model(input logic [3:0][7:0] xs, input logic [3:0][7:0] ws,
                                       input logic [7:0] b);
    int acc, r;
    acc = int'($signed(b)) * 16;
    for (int i = 0; i < 4; i++) acc += int'($signed(xs[i])) * int'($signed(ws[i]));
`ifdef SIGMOID_NEURON_MAC_ROUND_EN
    r = (acc + 8) >>> 4;
`else
    r = acc >>> 4;
`endif
    if (r > 127)  return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(r)};
  endfunction

  initial begin
    vecs[0] = '{"unit",     {4{8'h10}}, {4{8'h10}}, 8'h00, 8'h40, 1'b0};
    vecs[1] = '{"sat_pos",  {4{8'h7F}}, {4{8'h7F}}, 8'h10, 8'h7F, 1'b1};
    vecs[2] = '{"sat_neg",  {4{8'h80}}, {4{8'h7F}}, 8'h00, 8'h80, 1'b1};
`ifdef SIGMOID_NEURON_MAC_ROUND_EN
    vecs[3] = '{"small",    {4{8'h01}}, {4{8'h02}}, 8'h00, 8'h01, 1'b0};
    vecs[7] = '{"neg_lsb",  {8'h00,8'h00,8'h00,8'hFF}, {8'h00,8'h00,8'h00,8'h01}, 8'h00, 8'h00, 1'b0};
`else
    vecs[3] = '{"small",    {4{8'h01}}, {4{8'h02}}, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{"neg_lsb",  {8'h00,8'h00,8'h00,8'hFF}, {8'h00,8'h00,8'h00,8'h01}, 8'h00, 8'hFF, 1'b0};
`endif
    vecs[4] = '{"mixed",    {8'h08,8'hF0,8'h20,8'h10}, {4{8'h10}}, 8'h08, 8'h30, 1'b0};
    vecs[5] = '{"max_edge", {8'h00,8'h00,8'h00,8'h10}, {8'h00,8'h00,8'h00,8'h7F}, 8'h00, 8'h7F, 1'b0};
    vecs[6] = '{"min_edge", {8'h00,8'h00,8'h00,8'h10}, {8'h00,8'h00,8'h00,8'h80}, 8'h00, 8'h80, 1'b0};

    ifc.in_valid = 1'b0; ifc.x = '0; ifc.w = '0; ifc.bias = '0; ifc.out_ready = 1'b0;
    #12;
    check("rst_inrdy", 32'(ifc.in_ready), 32'd1);
    check("rst_ovld",  32'(ifc.out_valid), 32'd0);
    check("rst_z",     32'(ifc.z_value), 32'd0);
    check("rst_sat",   32'(ifc.sat), 32'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Bias is driven only on the first beat; later beats carry junk that must be ignored.
    for (int v = 0; v < 8; v++) begin
      for (int b = 0; b < 4; b++)
        send_beat(vecs[v].x[b], vecs[v].w[b], (b == 0) ? vecs[v].bias : 8'hAA);
      check({vecs[v].name, "_fin_ovld"},  32'(ifc.out_valid), 32'd0);
      check({vecs[v].name, "_fin_inrdy"}, 32'(ifc.in_ready), 32'd0);
      @(negedge clk);
      check({vecs[v].name, "_lat_ovld"},  32'(ifc.out_valid), 32'd1);
      get_result(vecs[v].name, vecs[v].z, vecs[v].sat, 0);
    end

    // Backpressure: result held for 5 cycles, taken on the 6th.
    for (int b = 0; b < 4; b++) send_beat(8'h10, 8'h10, 8'h00);
    get_result("backpress", 8'h40, 1'b0, 5);

    // Reset after a partial sum must leave no trace.
    send_beat(8'h7F, 8'h7F, 8'h70);
    send_beat(8'h7F, 8'h7F, 8'h70);
    rst_n = 1'b0; #1;
    check("midrst_ovld",  32'(ifc.out_valid), 32'd0);
    check("midrst_inrdy", 32'(ifc.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    for (int b = 0; b < 4; b++) send_beat(8'h10, 8'h10, 8'h00);
    get_result("postrst", 8'h40, 1'b0, 0);
    repeat (4) begin
      @(negedge clk);
      check("postrst_no_extra", 32'(ifc.out_valid), 32'd0);
    end

    // Streaming: driver keeps in_valid high through FIN/OUT; receiver toggles out_ready.
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          logic [3:0][7:0] xs, ws;
          logic [7:0] bv;
          logic [8:0] m;
          bv = 8'($urandom);
          for (int b = 0; b < 4; b++) begin xs[b] = 8'($urandom); ws[b] = 8'($urandom); end
          m = model(xs, ws, bv);
          for (int b = 0; b < 4; b++) begin
            send_beat(xs[b], ws[b], (b == 0) ? bv : 8'($urandom));
            if (b == 3) begin exp_q.push_back(m[7:0]); exp_sat_q.push_back(m[8]); end
            else begin
              int gap = $urandom_range(0, 2);
              repeat (gap) @(negedge clk);
            end
          end
          // Next neuron's first beat is presented immediately, while the block is busy.
        end
      end
      begin
        int got = 0, t = 0;
        logic       held = 1'b0;
        logic [7:0] prev_z = '0;
        while (got < 12 && t < 2000) begin
          @(negedge clk); t++;
          if (held && ifc.out_valid) check("rand_hold", 32'(ifc.z_value), 32'(prev_z));
          ifc.out_ready = 1'($urandom_range(0, 1));
          if (ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) check("rand_unexpected", 32'd1, 32'd0);
            else begin
              check("rand_z",   32'(ifc.z_value), 32'(exp_q.pop_front()));
              check("rand_sat", 32'(ifc.sat), 32'(exp_sat_q.pop_front()));
            end
            got++;
            held = 1'b0;
          end else begin
            held = ifc.out_valid;
            prev_z = ifc.z_value;
          end
        end
        if (got < 12) check("rand_timeout", 32'(got), 32'd12);
        @(negedge clk); ifc.out_ready = 1'b0;
      end
    join
    check("rand_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
